// File: rtl/scalar_mul_ram_sequencer.sv
// scalar_mul_ram_sequencer: fetches k/Px/Py over RAM port B, runs the scalar-mul core, writes Qx/Qy back.
// Optional WAIT watchdog enabled by defining SCALAR_SEQ_TIMEOUT_EN.
module scalar_mul_ram_sequencer #(
    parameter int Data           = 256,
    parameter int Addr           = 5,
    parameter int K_ADDR         = 0,
    parameter int PX_ADDR        = 1,
    parameter int PY_ADDR        = 2,
    parameter int QX_ADDR        = 3,
    parameter int QY_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [Data-1:0] command,
    output logic [Data-1:0] status,
    output logic            b_w,
    output logic [Addr:0]   b_adbus,
    output logic [Data-1:0] b_data_in,
    input  logic [Data-1:0] b_data_out,
    output logic            core_start,
    output logic [Data-1:0] core_k,
    output logic [Data-1:0] core_px,
    output logic [Data-1:0] core_py,
    input  logic            core_done,
    input  logic [Data-1:0] core_qx,
    input  logic [Data-1:0] core_qy
);
    localparam int AW = Addr + 1;
    typedef enum logic [3:0] {IDLE, RD_K, RD_PX, RD_PY, CAP_PY, START, WAIT, WR_QX, WR_QY} state_t;
    state_t          state;
    logic            go_q;
    logic            done;
    logic            err;
    logic [7:0]      jobs;
    logic [Data-1:0] qx_r;
    logic [Data-1:0] qy_r;
    logic            unused_cmd;
    assign unused_cmd = ^command[Data-1:1];
    assign b_data_in  = (state == WR_QY) ? qy_r : qx_r;
    assign status     = {{(Data-16){1'b0}}, jobs, 5'b0, err, done, state != IDLE};
`ifdef SCALAR_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            go_q       <= 1'b0;
            done       <= 1'b0;
            jobs       <= 8'd0;
            core_start <= 1'b0;
            b_w        <= 1'b0;
            b_adbus    <= '0;
            core_k     <= '0;
            core_px    <= '0;
            core_py    <= '0;
            qx_r       <= '0;
            qy_r       <= '0;
`ifdef SCALAR_SEQ_TIMEOUT_EN
            err        <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            go_q       <= command[0];
            core_start <= 1'b0;
            b_w        <= 1'b0;
            case (state)
                IDLE: if (command[0] && !go_q) begin
                    state   <= RD_K;
                    b_adbus <= AW'(K_ADDR);
                    done    <= 1'b0;
`ifdef SCALAR_SEQ_TIMEOUT_EN
                    err     <= 1'b0;
`endif
                end
                RD_K: begin
                    state   <= RD_PX;
                    b_adbus <= AW'(PX_ADDR);
                end
                // read data lags the address by one cycle, so each capture trails its fetch
                RD_PX: begin
                    state   <= RD_PY;
                    b_adbus <= AW'(PY_ADDR);
                    core_k  <= b_data_out;
                end
                RD_PY: begin
                    state   <= CAP_PY;
                    core_px <= b_data_out;
                end
                CAP_PY: begin
                    state      <= START;
                    core_py    <= b_data_out;
                    core_start <= 1'b1;
                end
                START: begin
                    state <= WAIT;
`ifdef SCALAR_SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: if (core_done) begin
                    state   <= WR_QX;
                    qx_r    <= core_qx;
                    qy_r    <= core_qy;
                    b_w     <= 1'b1;
                    b_adbus <= AW'(QX_ADDR);
                end
`ifdef SCALAR_SEQ_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state   <= IDLE;
                    err     <= 1'b1;
                    b_adbus <= '0;
                end else
                    wait_cnt <= wait_cnt + TW'(1);
`endif
                WR_QX: begin
                    state   <= WR_QY;
                    b_w     <= 1'b1;
                    b_adbus <= AW'(QY_ADDR);
                end
                WR_QY: begin
                    state   <= IDLE;
                    b_adbus <= '0;
                    done    <= 1'b1;
                    jobs    <= jobs + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scalar_mul_ram_sequencer.sv
// tb_scalar_mul_ram_sequencer: random jobs against a cycle-timeline model of the sequencer,
// plus directed literal checks for latency, go-edge rules, mid-job reset and counter wrap.
module tb_scalar_mul_ram_sequencer;
    localparam int D  = 256;
    localparam int A  = 5;
    localparam int TO = 16;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [D-1:0] command, status, b_data_in, b_data_out, core_k, core_px, core_py, core_qx, core_qy;
    logic         b_w, core_start, core_done;
    logic [A:0]   b_adbus;

    scalar_mul_ram_sequencer #(.Data(D), .Addr(A), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .status(status),
        .b_w(b_w), .b_adbus(b_adbus), .b_data_in(b_data_in), .b_data_out(b_data_out),
        .core_start(core_start), .core_k(core_k), .core_px(core_px), .core_py(core_py),
        .core_done(core_done), .core_qx(core_qx), .core_qy(core_qy)
    );

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [D-1:0] rnd();
        logic [D-1:0] r;
        for (int i = 0; i < D / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // RAM behind port B: registered read, write at the end of the write cycle
    logic [D-1:0] ram [0:63];
    always @(posedge clk) begin
        if (b_w) ram[b_adbus] <= b_data_in;
        b_data_out <= ram[b_adbus];
    end

    // core: answers core_delay cycles into WAIT (negative = never); strays only while go is low
    int           core_delay = 3, core_left = 0;
    bit           stray_en = 0;
    logic [D-1:0] next_qx, next_qy;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            if (core_delay == 0) begin
                core_done <= 1'b1; core_qx <= next_qx; core_qy <= next_qy;
            end else if (core_delay > 0) core_left <= core_delay;
        end else if (core_left > 0) begin
            if (core_left == 1) begin
                core_done <= 1'b1; core_qx <= next_qx; core_qy <= next_qy;
            end
            core_left <= core_left - 1;
        end else if (stray_en && !command[0] && $urandom_range(1, 0) == 1) begin
            core_done <= 1'b1; core_qx <= rnd(); core_qy <= rnd();
        end
    end

    int n_start = 0, n_wr = 0;
    always @(posedge clk) begin
        if (core_start) n_start++;
        if (b_w) n_wr++;
    end

    // timeline model: m_n is the cycle index since the accepting edge, m_d the cycle done was seen
    bit           m_busy, m_done, m_err, m_goq;
    int           m_n, m_d;
    logic [7:0]   m_cnt;
    logic [D-1:0] m_qx, m_qy, exp_k, exp_px, exp_py;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_goq = 0; m_n = 0; m_d = 0; m_cnt = 0; m_qx = 0; m_qy = 0;
        end else begin
            if (!m_busy) begin
                if (command[0] && !m_goq) begin
                    m_busy = 1; m_n = 1; m_d = 0; m_done = 0; m_err = 0;
                end
            end else begin
                if (m_d == 0 && m_n >= 6 && core_done) begin
                    m_d = m_n; m_qx = core_qx; m_qy = core_qy;
                end
`ifdef SCALAR_SEQ_TIMEOUT_EN
                else if (m_d == 0 && m_n == 5 + TO) begin
                    m_busy = 0; m_err = 1;
                end
`endif
                if (m_d != 0 && m_n == m_d + 2) begin
                    m_busy = 0; m_done = 1; m_cnt = m_cnt + 8'd1;
                end
                m_n++;
            end
            m_goq = command[0];
        end
    end

    always @(negedge clk) begin
        logic [D-1:0] es;
        bit ew;
        es = '0;
        es[15:8] = m_cnt; es[2] = m_err; es[1] = m_done; es[0] = m_busy;
        ew = m_busy && m_d != 0 && (m_n == m_d + 1 || m_n == m_d + 2);
        chk("status", status, es);
        chk("core_start", core_start, m_busy && m_n == 5);
        chk("b_w", b_w, ew);
        if (!m_busy) chk("adbus_idle", b_adbus, 0);
        else if (m_n >= 1 && m_n <= 3) chk("adbus_fetch", b_adbus, m_n - 1);
        if (ew) begin
            chk("adbus_wr", b_adbus, (m_n == m_d + 1) ? 3 : 4);
            chk("data_wr", b_data_in, (m_n == m_d + 1) ? m_qx : m_qy);
        end
        if (m_busy && m_n == 5) begin
            chk("core_k", core_k, exp_k);
            chk("core_px", core_px, exp_px);
            chk("core_py", core_py, exp_py);
        end
    end

    task automatic run_job(input int max, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!status[1] && lat < max);
        chk("job_done", status[1], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, s0, w0, k;
        logic [D-1:0] sk, spx, spy;
        command = '0; next_qx = 'h11; next_qy = 'h22;
        ram[0] = 5; ram[1] = 7; ram[2] = 9; ram[3] = 0; ram[4] = 0;
        exp_k = 5; exp_px = 7; exp_py = 9;
        repeat (3) @(negedge clk);
        chk("reset_status", status, 0);
        chk("reset_b_w", b_w, 0);
        chk("reset_k", core_k, 0);
        rst_n = 1;
        @(negedge clk);
        command = 1;
        lat = 0; sk = 0; spx = 0; spy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (core_start) begin sk = core_k; spx = core_px; spy = core_py; end
        end while (!status[1] && lat < 40);
        chk("first_latency", lat, 12);
        chk("first_k", sk, 5);
        chk("first_px", spx, 7);
        chk("first_py", spy, 9);
        chk("ram_qx", ram[3], 'h11);
        chk("ram_qy", ram[4], 'h22);
        chk("first_status", status, 'h0102);

        s0 = n_start;
        repeat (50) @(negedge clk);
        chk("held_go_no_start", n_start - s0, 0);
        command = 0; next_qx = 'h33; next_qy = 'h44;
        @(negedge clk);
        command = 1;
        run_job(60, lat);
        chk("second_status", status, 'h0202);
        chk("second_ram_qx", ram[3], 'h33);

        core_delay = 20; command = 0;
        @(negedge clk);
        s0 = n_start; w0 = n_wr; command = 1;
        repeat (8) @(negedge clk);
        command = 0;
        @(negedge clk);
        command = 1;
        run_job(60, lat);
        repeat (5) @(negedge clk);
        chk("wait_edge_starts", n_start - s0, 1);
        chk("wait_edge_writes", n_wr - w0, 2);
        chk("third_status", status, 'h0302);

        core_delay = 2; command = 0; ram[3] = 'hdead; next_qx = 'hbeef;
        @(negedge clk);
        command = 1; k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!b_w && k < 40);
        chk("reached_wr_qx", b_w, 1);
        #2 rst_n = 0;
        #1 chk("b_w_async_drop", b_w, 0);
        command = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_status", status, 0);
        chk("post_reset_adbus", b_adbus, 0);
        chk("no_partial_write", ram[3], 'hdead);

`ifdef SCALAR_SEQ_TIMEOUT_EN
        core_delay = -1; ram[3] = 'haaaa; ram[4] = 'hbbbb;
        @(negedge clk);
        command = 1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!status[2] && lat < 60);
        chk("timeout_latency", lat, 6 + TO);
        chk("timeout_status", status, 'h0004);
        chk("timeout_ram_qx", ram[3], 'haaaa);
        chk("timeout_ram_qy", ram[4], 'hbbbb);
`endif

        stray_en = 1;
        for (int j = 0; j < 256; j++) begin
            command = 0;
            ram[0] = rnd(); ram[1] = rnd(); ram[2] = rnd();
            exp_k = ram[0]; exp_px = ram[1]; exp_py = ram[2];
            next_qx = rnd(); next_qy = rnd();
            core_delay = $urandom_range(6, 0);
            @(negedge clk);
            command = 1;
            run_job(60, lat);
            chk("job_latency", lat, 9 + core_delay);
            chk("job_ram_qx", ram[3], next_qx);
            chk("job_ram_qy", ram[4], next_qy);
        end
        chk("wrap_status", status, 'h0002);
        stray_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
